reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- 8-entry circular reorder buffer for the Tomasulo-style core.
- Allocates the ROB tag (ROBTail) that the register result status table records at dispatch.
- Captures results broadcast on two CDB slots and retires them in program order to the register file.
- Serves two operand lookups so reservation stations can read completed but uncommitted values.

Parameters:
- DEPTH, 8, number of entries. Fixed to 8 by the 3-bit ROB tag; not to be overridden.
- DATA_W, 32, result width.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- append  in  1  allocate the entry at ROBTail this cycle.
- WA  in  4  destination architectural register of the allocated instruction.
- NoWrite  in  1  allocated instruction has no register destination.
- flush  in  1  synchronous discard of all entries.
- CDB  in  148  common data bus.
  - Slot 0: valid [3], tag [2:0], data [35:4].
  - Slot 1: valid [39], tag [38:36], data [71:40].
  - Bits [147:72] are ignored by this block.
- rob_query  in  6  two ROB tags: [2:0] operand A, [5:3] operand B.
- ROBTail  out  3  tag the next append will receive.
- Full  out  1  count == 8.
- Empty  out  1  count == 0.
- rob_ready  out  2  per query: entry valid and result captured ([0]=A, [1]=B).
- rob_value  out  64  per query captured data ([31:0]=A, [63:32]=B). Zero when the matching rob_ready bit is 0.
- commit_valid  out  1  head entry retires at the next edge.
- commit_WA  out  4  head WA.
- commit_NoWrite  out  1  head NoWrite.
- commit_tag  out  3  head index. Lets the status table clear busy only when its stored index still matches.
- commit_data  out  32  head result.

Behaviour:
- State:
  - Per entry: valid, done, WA[3:0], NoWrite, data[31:0].
  - head[2:0], tail[2:0], count[3:0].
- Reset (async) sets head=tail=count=0 and clears all valid/done.
  - Resulting outputs: ROBTail=0, Empty=1, Full=0, commit_valid=0, rob_ready=0, rob_value=0, commit_* = 0.
  - Entry data are also cleared.
- ROBTail=tail, combinational.
- Append is accepted when append && !Full, evaluated before the edge.
  - Entry[tail] is set: valid=1, done=0, WA, NoWrite.
  - tail increments mod 8 (7 wraps to 0).
  - append while Full is ignored, with no state change, even if a commit frees a slot that same edge.
- CDB capture: for each slot with valid=1 whose tag hits an entry with valid=1, set done=1 and data=slot data at the edge.
  - A hit on an invalid entry is ignored.
  - Both slots with the same tag: slot 1 data is written.
  - Result latency: broadcast in cycle N makes rob_ready/commit eligibility visible in cycle N+1. There is no same-cycle CDB bypass; reservation stations snoop the CDB themselves.
- Commit:
  - commit_valid = entry[head].valid && entry[head].done, combinational.
  - commit_* fields present the head entry whenever commit_valid=1 and are 0 otherwise.
  - On the edge with commit_valid=1: entry[head].valid and done are cleared, and head increments mod 8.
  - At most one commit per cycle.
  - commit_NoWrite=1 entries still retire; the register file suppresses the write.
- count: +1 on an accepted append, -1 on a commit, unchanged when both occur.
  - Simultaneous append and commit with count==8 leaves count=7.
  - Append is rejected because Full was 1.
- flush (synchronous): behaves like reset at the edge and overrides append, CDB and commit in that cycle. commit_valid is still driven combinationally during the flush cycle.
- Query: rob_ready[i] = entry[q].valid && entry[q].done, with rob_value gated accordingly. Purely combinational.

Test Plan:
- Reset, then 3 appends (WA=1,2,3, NoWrite=0) -> ROBTail 0,1,2 then 3; count=3; Empty=0; commit_valid=0.
- CDB slot0 tag=1, data=0xAAAA0001 and slot1 tag=0, data=0x5 in the same cycle -> next cycle commit_valid=1, commit_tag=0, commit_WA=1, data=5. Following cycle: commit_tag=1, WA=2, data=0xAAAA0001. Tag 2 is not ready, so commit_valid=0.
- Fill 8 entries -> Full=1. A 9th append changes nothing. With head done, append+commit in the same cycle -> count 7, ROBTail unchanged. tail wraps 7->0 on the next append.
- CDB broadcast to an invalid tag 5 -> no state change; rob_query=5 returns rob_ready=0, value=0.
- Out-of-order completion: tags 2 then 0 then 1 complete -> commits strictly in order 0,1,2, one per cycle after tag 1 completes.
- Assert Reset asynchronously mid-stream, then flush while the head is done -> outputs zero immediately on Reset; after the flush edge Empty=1, ROBTail=0, and the head is not retired.

Source files
------------

// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer: allocates ROB tags at dispatch, captures two CDB
// result slots, retires in program order and serves two operand lookups.

module rob_entry #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              flush,
    input  logic              alloc,
    input  logic [3:0]        alloc_wa,
    input  logic              alloc_nowrite,
    input  logic              retire,
    input  logic              hit0,
    input  logic              hit1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              valid,
    output logic              done,
    output logic [3:0]        wa,
    output logic              nowrite,
    output logic [DATA_W-1:0] data
);
    // alloc and retire never target the same slot: that needs count 0 (no retire) or
    // count 8 (no alloc). A retiring entry must not be re-marked done by a late capture.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            valid   <= 1'b0;
            done    <= 1'b0;
            wa      <= '0;
            nowrite <= 1'b0;
            data    <= '0;
        end else if (flush) begin
            valid   <= 1'b0;
            done    <= 1'b0;
            wa      <= '0;
            nowrite <= 1'b0;
            data    <= '0;
        end else if (alloc) begin
            valid   <= 1'b1;
            done    <= 1'b0;
            wa      <= alloc_wa;
            nowrite <= alloc_nowrite;
        end else if (retire) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (valid && (hit0 || hit1)) begin
            done <= 1'b1;
            data <= hit1 ? data1 : data0;
        end
    end
endmodule

module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                append,
    input  logic [3:0]          WA,
    input  logic                NoWrite,
    input  logic                flush,
    input  logic [147:0]        CDB,
    input  logic [5:0]          rob_query,
    output logic [2:0]          ROBTail,
    output logic                Full,
    output logic                Empty,
    output logic [1:0]          rob_ready,
    output logic [2*DATA_W-1:0] rob_value,
    output logic                commit_valid,
    output logic [3:0]          commit_WA,
    output logic                commit_NoWrite,
    output logic [2:0]          commit_tag,
    output logic [DATA_W-1:0]   commit_data
);
    logic [2:0] head, tail;
    logic [3:0] count;

    logic [DEPTH-1:0]             e_valid, e_done, e_nowrite;
    logic [DEPTH-1:0][3:0]        e_wa;
    logic [DEPTH-1:0][DATA_W-1:0] e_data;

    logic              s0_v, s1_v;
    logic [2:0]        s0_tag, s1_tag;
    logic [DATA_W-1:0] s0_data, s1_data;
    logic              unused_cdb;

    assign s0_v       = CDB[3];
    assign s0_tag     = CDB[2:0];
    assign s0_data    = CDB[35:4];
    assign s1_v       = CDB[39];
    assign s1_tag     = CDB[38:36];
    assign s1_data    = CDB[71:40];
    assign unused_cdb = ^CDB[147:72];

    logic accept;
    assign Full         = (count == 4'(DEPTH));
    assign Empty        = (count == 4'd0);
    assign ROBTail      = tail;
    assign accept       = append && !Full;
    assign commit_valid = e_valid[head] && e_done[head];

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rob_entry #(.DATA_W(DATA_W)) u_ent (
            .CLK           (CLK),
            .Reset         (Reset),
            .flush         (flush),
            .alloc         (accept && (tail == 3'(g))),
            .alloc_wa      (WA),
            .alloc_nowrite (NoWrite),
            .retire        (commit_valid && (head == 3'(g))),
            .hit0          (s0_v && (s0_tag == 3'(g))),
            .hit1          (s1_v && (s1_tag == 3'(g))),
            .data0         (s0_data),
            .data1         (s1_data),
            .valid         (e_valid[g]),
            .done          (e_done[g]),
            .wa            (e_wa[g]),
            .nowrite       (e_nowrite[g]),
            .data          (e_data[g])
        );
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept)       tail <= tail + 3'd1;
            if (commit_valid) head <= head + 3'd1;
            case ({accept, commit_valid})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        commit_WA      = '0;
        commit_NoWrite = 1'b0;
        commit_tag     = '0;
        commit_data    = '0;
        if (commit_valid) begin
            commit_WA      = e_wa[head];
            commit_NoWrite = e_nowrite[head];
            commit_tag     = head;
            commit_data    = e_data[head];
        end
    end

    for (genvar q = 0; q < 2; q++) begin : g_query
        logic [2:0] qt;
        assign qt           = rob_query[3*q +: 3];
        assign rob_ready[q] = e_valid[qt] && e_done[qt];
        assign rob_value[q*DATA_W +: DATA_W] = rob_ready[q] ? e_data[qt] : '0;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a program-order queue model is compared every
// cycle, and hand-computed literals pin the key scenarios.

module tb_reorder_buffer;
    localparam logic [75:0] JUNK = 76'h5A5A5A5A5A5A5A5A5A5;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         append;
    logic [3:0]   WA;
    logic         NoWrite;
    logic         flush;
    logic [147:0] CDB;
    logic [5:0]   rob_query;
    logic [2:0]   ROBTail;
    logic         Full, Empty;
    logic [1:0]   rob_ready;
    logic [63:0]  rob_value;
    logic         commit_valid;
    logic [3:0]   commit_WA;
    logic         commit_NoWrite;
    logic [2:0]   commit_tag;
    logic [31:0]  commit_data;

    int errors = 0;
    int checks = 0;

    reorder_buffer dut (
        .CLK(CLK), .Reset(Reset), .append(append), .WA(WA), .NoWrite(NoWrite),
        .flush(flush), .CDB(CDB), .rob_query(rob_query), .ROBTail(ROBTail),
        .Full(Full), .Empty(Empty), .rob_ready(rob_ready), .rob_value(rob_value),
        .commit_valid(commit_valid), .commit_WA(commit_WA),
        .commit_NoWrite(commit_NoWrite), .commit_tag(commit_tag),
        .commit_data(commit_data)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-flight instructions in program order; tag = (mhead + position) mod 8.
    typedef struct {
        logic [3:0]  wa;
        logic        nw;
        logic        done;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    int   mhead = 0;

    initial forever begin
        bit com, acc;
        logic [2:0] tg;
        @(posedge CLK or posedge Reset);
        if (Reset || flush) begin
            q.delete();
            mhead = 0;
        end else begin
            com = (q.size() > 0) && q[0].done;
            acc = append && (q.size() < 8);
            for (int i = 0; i < q.size(); i++) begin
                tg = 3'((mhead + i) % 8);
                if (CDB[39] && CDB[38:36] == tg) begin
                    q[i].done = 1'b1;
                    q[i].data = CDB[71:40];
                end else if (CDB[3] && CDB[2:0] == tg) begin
                    q[i].done = 1'b1;
                    q[i].data = CDB[35:4];
                end
            end
            if (com) begin
                void'(q.pop_front());
                mhead = (mhead + 1) % 8;
            end
            if (acc) q.push_back('{WA, NoWrite, 1'b0, 32'h0});
        end
    end

    initial forever begin
        int n, off;
        logic [2:0] tg;
        logic [1:0] erdy;
        logic [63:0] eval;
        logic [40:0] ecom;
        @(negedge CLK);
        n = q.size();
        chk("tail", 64'(ROBTail), 64'((mhead + n) % 8));
        chk("full", 64'(Full), 64'(n == 8));
        chk("empty", 64'(Empty), 64'(n == 0));
        ecom = '0;
        if (n > 0 && q[0].done) ecom = {1'b1, q[0].wa, q[0].nw, 3'(mhead), q[0].data};
        chk("commit", 64'({commit_valid, commit_WA, commit_NoWrite, commit_tag, commit_data}),
            64'(ecom));
        erdy = '0;
        eval = '0;
        for (int k = 0; k < 2; k++) begin
            tg  = rob_query[3*k +: 3];
            off = (int'(tg) - mhead + 8) % 8;
            if (off < n && q[off].done) begin
                erdy[k] = 1'b1;
                eval[32*k +: 32] = q[off].data;
            end
        end
        chk("ready", 64'(rob_ready), 64'(erdy));
        chk("value", rob_value, eval);
    end

    task automatic idle();
        append  = 1'b0;
        NoWrite = 1'b0;
        flush   = 1'b0;
        CDB     = {JUNK, 72'h0};
    endtask

    // Inputs change at negedge+1 / posedge+1, away from the model and compare samples.
    task automatic step();
        @(posedge CLK);
        #1 idle();
        @(negedge CLK);
        #1;
    endtask

    task automatic cdb(input bit v0, input logic [2:0] t0, input logic [31:0] d0,
                       input bit v1, input logic [2:0] t1, input logic [31:0] d1);
        CDB = {JUNK, d1, v1, t1, d0, v0, t0};
    endtask

    task automatic push(input logic [3:0] wa, input bit nw);
        WA = wa;
        NoWrite = nw;
        append = 1'b1;
    endtask

    initial begin
        Reset = 1'b1;
        WA = '0;
        rob_query = '0;
        idle();
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_tail", 64'(ROBTail), 64'd0);
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_full", 64'(Full), 64'd0);
        chk("rst_cv", 64'(commit_valid), 64'd0);
        chk("rst_ready", 64'(rob_ready), 64'd0);
        chk("rst_value", rob_value, 64'd0);

        for (int i = 0; i < 3; i++) begin
            chk("alloc_tag", 64'(ROBTail), 64'(i));
            push(4'(i + 1), 1'b0);
            step();
        end
        chk("t1_tail", 64'(ROBTail), 64'd3);
        chk("t1_empty", 64'(Empty), 64'd0);
        chk("t1_cv", 64'(commit_valid), 64'd0);

        cdb(1'b1, 3'd1, 32'hAAAA0001, 1'b1, 3'd0, 32'h5);
        step();
        chk("t2_c0", 64'({commit_valid, commit_tag, commit_WA, commit_data}),
            64'({1'b1, 3'd0, 4'd1, 32'h5}));
        step();
        chk("t2_c1", 64'({commit_valid, commit_tag, commit_WA, commit_data}),
            64'({1'b1, 3'd1, 4'd2, 32'hAAAA0001}));
        step();
        chk("t2_c2_wait", 64'(commit_valid), 64'd0);

        cdb(1'b1, 3'd5, 32'h1234, 1'b0, 3'd0, 32'h0);
        rob_query = {3'd2, 3'd5};
        step();
        chk("inv_ready", 64'(rob_ready), 64'd0);
        chk("inv_value", rob_value, 64'd0);
        chk("inv_tail", 64'(ROBTail), 64'd3);

        for (int i = 0; i < 7; i++) begin
            push(4'(4 + i), 1'b0);
            step();
            chk("fill_tail", 64'(ROBTail), 64'((4 + i) % 8));
        end
        chk("fill_full", 64'(Full), 64'd1);
        push(4'd15, 1'b0);
        step();
        chk("ovf_full", 64'(Full), 64'd1);
        chk("ovf_tail", 64'(ROBTail), 64'd2);
        cdb(1'b1, 3'd2, 32'h22, 1'b0, 3'd0, 32'h0);
        step();
        chk("full_head", 64'({commit_valid, commit_tag, commit_WA}), 64'({1'b1, 3'd2, 4'd3}));
        push(4'd9, 1'b0);
        step();
        chk("ac_full", 64'(Full), 64'd0);
        chk("ac_tail", 64'(ROBTail), 64'd2);
        push(4'd9, 1'b0);
        step();
        chk("refill_tail", 64'(ROBTail), 64'd3);

        flush = 1'b1;
        step();
        chk("fl_empty", 64'(Empty), 64'd1);
        chk("fl_tail", 64'(ROBTail), 64'd0);

        for (int i = 0; i < 3; i++) begin
            push(4'(i + 1), 1'b0);
            step();
        end
        cdb(1'b1, 3'd2, 32'h222, 1'b0, 3'd0, 32'h0);
        rob_query = {3'd0, 3'd2};
        step();
        chk("ooo_wait", 64'(commit_valid), 64'd0);
        chk("ooo_qready", 64'(rob_ready), 64'b01);
        chk("ooo_qvalue", rob_value, 64'h0000_0000_0000_0222);
        cdb(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 32'h100);
        step();
        chk("ooo_c0", 64'({commit_valid, commit_tag, commit_data}), 64'({1'b1, 3'd0, 32'h100}));
        cdb(1'b1, 3'd1, 32'h111, 1'b0, 3'd0, 32'h0);
        step();
        chk("ooo_c1", 64'({commit_valid, commit_tag, commit_data}), 64'({1'b1, 3'd1, 32'h111}));
        step();
        chk("ooo_c2", 64'({commit_valid, commit_tag, commit_data}), 64'({1'b1, 3'd2, 32'h222}));
        step();
        chk("ooo_empty", 64'({commit_valid, Empty}), 64'b01);

        push(4'd5, 1'b1);
        step();
        cdb(1'b1, 3'd3, 32'hDEAD, 1'b1, 3'd3, 32'hBEEF);
        step();
        chk("dual_slot", 64'({commit_valid, commit_NoWrite, commit_tag, commit_data}),
            64'({1'b1, 1'b1, 3'd3, 32'hBEEF}));
        step();
        chk("nowrite_ret", 64'(Empty), 64'd1);

        push(4'd6, 1'b0);
        step();
        push(4'd7, 1'b0);
        step();
        cdb(1'b1, 3'd4, 32'h44, 1'b0, 3'd0, 32'h0);
        step();
        chk("pre_rst", 64'({commit_valid, commit_tag}), 64'({1'b1, 3'd4}));
        Reset = 1'b1;
        #1;
        chk("arst_tail", 64'(ROBTail), 64'd0);
        chk("arst_empty", 64'(Empty), 64'd1);
        chk("arst_commit", 64'({commit_valid, commit_data}), 64'd0);
        #5 Reset = 1'b0;
        @(negedge CLK);
        #1;
        chk("post_rst", 64'({Empty, ROBTail}), 64'({1'b1, 3'd0}));

        push(4'd8, 1'b0);
        step();
        cdb(1'b1, 3'd0, 32'h99, 1'b0, 3'd0, 32'h0);
        rob_query = 6'd0;
        step();
        chk("fh_head", 64'({commit_valid, commit_tag, commit_data}), 64'({1'b1, 3'd0, 32'h99}));
        flush = 1'b1;
        push(4'd2, 1'b0);
        cdb(1'b1, 3'd1, 32'h77, 1'b0, 3'd0, 32'h0);
        #1;
        chk("fh_cv_during", 64'(commit_valid), 64'd1);
        step();
        chk("fh_empty", 64'(Empty), 64'd1);
        chk("fh_tail", 64'(ROBTail), 64'd0);
        chk("fh_cv", 64'(commit_valid), 64'd0);
        chk("fh_ready", 64'(rob_ready), 64'd0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
